// File: rtl/noise_voice_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : noise_voice_ctrl
// Description : Noise-voice sequencer: note handshake, LFSR step strobe,
//               tick-based note timing, linear release and sample scaling.
// Revision    : 1.0 - initial release
// ============================================================================
module noise_voice_ctrl #(
    parameter int TICK_DIV = 4,
    parameter int PER_W    = 16,
    parameter int DUR_W    = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [PER_W-1:0] cmd_period,
    input  logic [3:0]       cmd_volume,
    input  logic [DUR_W-1:0] cmd_duration,
    input  logic             cmd_release,
    input  logic             stop,
    input  logic [7:0]       noise_in,
    output logic             noise_step,
    output logic [7:0]       audio_out,
    output logic             busy,
    output logic             done
);

    localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(TICK_DIV - 1);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] PLAY    = 2'd1;
    localparam logic [1:0] RELEASE = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [PER_W-1:0] per_q, per_d;
    logic [PER_W-1:0] pcnt_q, pcnt_d;
    logic [DUR_W-1:0] dur_q, dur_d;
    logic [PRE_W-1:0] pre_q, pre_d;
    logic [3:0]       vol_q, vol_d;
    logic             rel_q, rel_d;
    logic             done_q, done_d;
    logic [7:0]       audio_q, audio_d;

    logic              tick;
    logic signed [8:0]  centered;
    logic signed [13:0] product;
    logic signed [13:0] shifted;

    assign tick       = (pre_q == '0);
    assign cmd_ready  = (state_q == IDLE);
    assign busy       = (state_q != IDLE);
    assign noise_step = busy && (pcnt_q == '0);
    assign done       = done_q;
    assign audio_out  = audio_q;

    always_comb begin
        state_d = state_q;
        per_d   = per_q;
        pcnt_d  = pcnt_q;
        dur_d   = dur_q;
        pre_d   = pre_q;
        vol_d   = vol_q;
        rel_d   = rel_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    per_d  = cmd_period;
                    pcnt_d = cmd_period;
                    dur_d  = cmd_duration;
                    vol_d  = cmd_volume;
                    rel_d  = cmd_release;
                    pre_d  = PRE_MAX;
                    if (cmd_duration == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = PLAY;
                    end
                end
            end
            PLAY, RELEASE: begin
                pcnt_d = (pcnt_q == '0) ? per_q : pcnt_q - 1'b1;
                pre_d  = tick ? PRE_MAX : pre_q - 1'b1;
                if (stop) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else if (tick && state_q == PLAY) begin
                    dur_d = dur_q - 1'b1;
                    if (dur_q == DUR_W'(1)) begin
                        if (rel_q && vol_q != 4'd0) begin
                            state_d = RELEASE;
                        end else begin
                            state_d = IDLE;
                            done_d  = 1'b1;
                        end
                    end
                end else if (tick) begin
                    // Volume held for one full tick after sustain before first decrement
                    vol_d = vol_q - 1'b1;
                    if (vol_q == 4'd1) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Scale against the next-cycle volume/state so audio tracks the visible state
    always_comb begin
        centered = $signed({1'b0, noise_in}) - 9'sd128;
        product  = centered * $signed({1'b0, vol_d});
        shifted  = product >>> 4;
        audio_d  = (state_d == IDLE) ? 8'h80 : 8'(14'sd128 + shifted);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            per_q   <= '0;
            pcnt_q  <= '0;
            dur_q   <= '0;
            pre_q   <= '0;
            vol_q   <= '0;
            rel_q   <= 1'b0;
            done_q  <= 1'b0;
            audio_q <= 8'h80;
        end else begin
            state_q <= state_d;
            per_q   <= per_d;
            pcnt_q  <= pcnt_d;
            dur_q   <= dur_d;
            pre_q   <= pre_d;
            vol_q   <= vol_d;
            rel_q   <= rel_d;
            done_q  <= done_d;
            audio_q <= audio_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_noise_voice_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_noise_voice_ctrl
// Description : Directed self-checking bench for noise_voice_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_noise_voice_ctrl;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [15:0] cmd_period;
    logic [3:0]  cmd_volume;
    logic [15:0] cmd_duration;
    logic        cmd_release;
    logic        stop;
    logic [7:0]  noise_in;
    logic        noise_step;
    logic [7:0]  audio_out;
    logic        busy;
    logic        done;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    noise_voice_ctrl #(.TICK_DIV(4), .PER_W(16), .DUR_W(16)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_period   (cmd_period),
        .cmd_volume   (cmd_volume),
        .cmd_duration (cmd_duration),
        .cmd_release  (cmd_release),
        .stop         (stop),
        .noise_in     (noise_in),
        .noise_step   (noise_step),
        .audio_out    (audio_out),
        .busy         (busy),
        .done         (done)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic check_idle(input string tag, input logic exp_done);
        check({tag, " ready"}, 32'(cmd_ready), 32'd1);
        check({tag, " busy"},  32'(busy),      32'd0);
        check({tag, " step"},  32'(noise_step), 32'd0);
        check({tag, " audio"}, 32'(audio_out), 32'h80);
        check({tag, " done"},  32'(done),      32'(exp_done));
    endtask

    // Drive a command for one edge; returns at the negedge of the first cycle after accept
    task automatic send(input logic [15:0] per, input logic [3:0] vol,
                        input logic [15:0] dur, input logic rel);
        cmd_valid    = 1'b1;
        cmd_period   = per;
        cmd_volume   = vol;
        cmd_duration = dur;
        cmd_release  = rel;
        @(negedge clk);
        cmd_valid    = 1'b0;
    endtask

    initial begin
        reset_n      = 1'b0;
        cmd_valid    = 1'b0;
        cmd_period   = '0;
        cmd_volume   = '0;
        cmd_duration = '0;
        cmd_release  = 1'b0;
        stop         = 1'b0;
        noise_in     = 8'h00;

        // 1: reset with random inputs
        for (int i = 0; i < 3; i++) begin
            cmd_valid    = 1'($urandom);
            cmd_period   = 16'($urandom);
            cmd_volume   = 4'($urandom);
            cmd_duration = 16'($urandom);
            cmd_release  = 1'($urandom);
            stop         = 1'($urandom);
            noise_in     = 8'($urandom);
            @(negedge clk);
            check_idle($sformatf("rst%0d", i), 1'b0);
        end
        cmd_valid = 1'b0;
        stop      = 1'b0;
        reset_n   = 1'b1;
        @(negedge clk);
        check_idle("post_rst", 1'b0);

        // 2: period 3, vol 15, dur 2, no release
        noise_in = 8'hFF;
        send(16'd3, 4'd15, 16'd2, 1'b0);
        for (int k = 1; k <= 8; k++) begin
            check($sformatf("t2 busy c%0d", k),  32'(busy),       32'd1);
            check($sformatf("t2 ready c%0d", k), 32'(cmd_ready),  32'd0);
            check($sformatf("t2 step c%0d", k),  32'(noise_step), 32'((k % 4) == 0));
            check($sformatf("t2 audio c%0d", k), 32'(audio_out),  (k <= 4) ? 32'hF7 : 32'h08);
            check($sformatf("t2 done c%0d", k),  32'(done),       32'd0);
            if (k == 4) noise_in = 8'h00;
            @(negedge clk);
        end
        check_idle("t2 end", 1'b1);
        @(negedge clk);
        check_idle("t2 after", 1'b0);

        // 3: period 0, vol 3, dur 1, release
        noise_in = 8'h00;
        send(16'd0, 4'd3, 16'd1, 1'b1);
        for (int k = 1; k <= 16; k++) begin
            check($sformatf("t3 busy c%0d", k),  32'(busy),       32'd1);
            check($sformatf("t3 step c%0d", k),  32'(noise_step), 32'd1);
            check($sformatf("t3 audio c%0d", k), 32'(audio_out),
                  (k <= 8) ? 32'h68 : (k <= 12) ? 32'h70 : 32'h78);
            check($sformatf("t3 done c%0d", k),  32'(done),       32'd0);
            @(negedge clk);
        end
        check_idle("t3 end", 1'b1);
        @(negedge clk);
        check_idle("t3 after", 1'b0);

        // 4: zero-duration command
        send(16'd2, 4'd9, 16'd0, 1'b1);
        check_idle("t4 c1", 1'b1);
        @(negedge clk);
        check_idle("t4 c2", 1'b0);

        // stop alone in IDLE is ignored
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        check_idle("idle_stop", 1'b0);

        // 5: stop mid-note, then back-to-back command (with stop) on the done cycle
        noise_in = 8'hFF;
        send(16'd1, 4'd4, 16'd100, 1'b0);
        for (int k = 1; k <= 3; k++) begin
            check($sformatf("t5 busy c%0d", k),  32'(busy),       32'd1);
            check($sformatf("t5 step c%0d", k),  32'(noise_step), 32'((k % 2) == 0));
            check($sformatf("t5 audio c%0d", k), 32'(audio_out),  32'h9F);
            if (k == 3) stop = 1'b1;
            @(negedge clk);
        end
        check_idle("t5 stop", 1'b1);
        send(16'd0, 4'd4, 16'd1, 1'b0);
        stop = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            check($sformatf("t5b busy c%0d", k),  32'(busy),      32'd1);
            check($sformatf("t5b ready c%0d", k), 32'(cmd_ready), 32'd0);
            check($sformatf("t5b audio c%0d", k), 32'(audio_out), 32'h9F);
            @(negedge clk);
        end
        check_idle("t5b end", 1'b1);
        @(negedge clk);

        // 6: asynchronous reset mid-RELEASE
        noise_in = 8'h00;
        send(16'd0, 4'd2, 16'd1, 1'b1);
        repeat (5) @(negedge clk);
        check("t6 busy pre", 32'(busy), 32'd1);
        check("t6 audio pre", 32'(audio_out), 32'h70);
        #2 reset_n = 1'b0;
        #1 check_idle("t6 async", 1'b0);
        @(negedge clk);
        check_idle("t6 hold", 1'b0);
        reset_n = 1'b1;
        @(negedge clk);
        check_idle("t6 release", 1'b0);
        @(negedge clk);
        check_idle("t6 after", 1'b0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
